// File: rtl/climate_arbiter.sv
// Round-robin arbiter sharing one heater, one cooler and a zone valve bank
// among greenhouse zones, with minimum/maximum run time and dead time between grants.
//
// state  | meaning
// S_IDLE | plant off, searching for the next requesting zone from ptr
// S_RUN  | plant granted to zone gnt in frozen mode (heat or cool)
// S_DEAD | all-off dead time before the next arbitration
module climate_arbiter #(
   parameter int ZONES  = 4,
   parameter int MIN_ON = 16,
   parameter int MAX_ON = 64,
   parameter int DEAD   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ZONES-1:0] zone_en,
   input  logic [ZONES-1:0] heat_req,
   input  logic [ZONES-1:0] cool_req,
   output logic             heater_on,
   output logic             cooler_on,
   output logic [ZONES-1:0] valve,
   output logic [2:0]       grant_id,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

   localparam logic [7:0] MIN_M1  = 8'(MIN_ON - 1);
   localparam logic [7:0] MAX_M1  = 8'(MAX_ON - 1);
   localparam logic [7:0] DEAD_M1 = 8'(DEAD - 1);
   localparam logic [2:0] LAST    = 3'(ZONES - 1);

   state_t           state;
   logic [2:0]       ptr;
   logic [2:0]       gnt;
   logic             mode_heat;
   logic [7:0]       run_cnt;
   logic [7:0]       dead_cnt;

   logic [ZONES-1:0] req;
   logic [ZONES-1:0] win_oh;
   logic [ZONES-1:0] gnt_oh;
   logic [3:0]       idx;
   logic [2:0]       win;
   logic             found;
   logic             win_heat;
   logic             g_en;
   logic             g_hold;
   logic             others;
   logic             leave_run;

   // Rotating search starting at ptr; first requesting zone wins.
   always_comb begin
      req   = zone_en & (heat_req | cool_req);
      found = 1'b0;
      win   = ptr;
      idx   = '0;
      for (int k = 0; k < ZONES; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(ZONES))
            idx = idx - 4'(ZONES);
         if (!found && (|(req & (ZONES'(1) << idx)))) begin
            found = 1'b1;
            win   = idx[2:0];
         end
      end
   end

   assign win_oh    = ZONES'(1) << win;
   assign win_heat  = |(heat_req & win_oh);
   assign gnt_oh    = ZONES'(1) << gnt;
   assign g_en      = |(zone_en & gnt_oh);
   assign g_hold    = mode_heat ? |(heat_req & gnt_oh) : |(cool_req & gnt_oh);
   assign others    = |(req & ~gnt_oh);
   assign leave_run = !g_en
                    || ((run_cnt >= MIN_M1) && !g_hold)
                    || ((run_cnt >= MAX_M1) && others);

   // Outputs are decoded from the registered state one cycle later, so a
   // request seen at edge t drives the plant after edge t+1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= 3'd0;
         gnt       <= 3'd0;
         mode_heat <= 1'b0;
         run_cnt   <= 8'd0;
         dead_cnt  <= 8'd0;
         heater_on <= 1'b0;
         cooler_on <= 1'b0;
         valve     <= '0;
         grant_id  <= 3'd0;
         busy      <= 1'b0;
      end else begin
         heater_on <= (state == S_RUN) && mode_heat;
         cooler_on <= (state == S_RUN) && !mode_heat;
         valve     <= (state == S_RUN) ? gnt_oh : '0;
         busy      <= (state != S_IDLE);
         grant_id  <= (state != S_IDLE) ? gnt : 3'd0;

         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt       <= win;
                  mode_heat <= win_heat;
                  ptr       <= (win == LAST) ? 3'd0 : win + 3'd1;
                  run_cnt   <= 8'd0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (run_cnt != 8'hFF)
                  run_cnt <= run_cnt + 8'd1;
               if (leave_run) begin
                  dead_cnt <= 8'd0;
                  state    <= S_DEAD;
               end
            end
            S_DEAD: begin
               dead_cnt <= dead_cnt + 8'd1;
               if (dead_cnt == DEAD_M1)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/climate_arbiter.md
# climate_arbiter

- Shares one heater, one cooler and one zone valve bank among ZONES greenhouse zones.
- Each zone's temperature controller raises a heat or cool request. The arbiter grants the plant to one zone at a time, round-robin.
- It enforces a minimum run time, a maximum run time when other zones are waiting, and a dead time between grants.
- Heater and cooler are never on together. It sits between the per-zone temperature controllers and the actuator drivers.

## Interface

- ZONES, 4: number of zones, 2..8.
- MIN_ON, 16: minimum RUN cycles per grant, 1..255.
- MAX_ON, 64: RUN cycles after which a grant is preempted if another zone requests, MIN_ON..255.
- DEAD, 4: all-off cycles between grants, 1..255.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- zone_en  in  ZONES  per-zone enable. A disabled zone never requests.
- heat_req  in  ZONES  zone i requests heating.
- cool_req  in  ZONES  zone i requests cooling.
- heater_on  out  1  heater drive.
- cooler_on  out  1  cooler drive.
- valve  out  ZONES  one-hot zone valve; all zero when idle.
- grant_id  out  3  index of the granted zone, valid while busy.
- busy  out  1  high in RUN and DEAD.

## Operation

- Effective request: req[i] = zone_en[i] & (heat_req[i] | cool_req[i]). If both requests are high, heat wins (mode = heat).
- Outputs:
  - All outputs are registered. Reset value of every output is 0.
  - Internal state resets to: state = IDLE, ptr = 0, run_cnt = 0, dead_cnt = 0.
- State IDLE:
  - Outputs off.
  - If any req: search zones ptr, ptr+1, … mod ZONES; the first requesting zone g wins.
  - Register g and mode; set ptr = (g+1) mod ZONES, run_cnt = 0; go to RUN.
  - Otherwise stay in IDLE.
- State RUN:
  - valve = one-hot(g), grant_id = g, busy = 1.
  - heater_on = (mode == heat); cooler_on = (mode == cool).
  - run_cnt increments each RUN cycle and saturates at 255.
  - Mode is frozen for the whole grant. Only the granted mode's request bit of zone g holds the grant. A request for the opposite mode is re-arbitrated after DEAD.
  - Go to DEAD with dead_cnt = 0 when any of the following holds:
    - zone_en[g] = 0: immediate, ignores MIN_ON.
    - run_cnt ≥ MIN_ON-1 and the granted-mode request of zone g is low.
    - run_cnt ≥ MAX_ON-1 and req[j] = 1 for some j ≠ g.
- State DEAD:
  - heater_on = cooler_on = 0, valve = 0, busy = 1.
  - dead_cnt increments; when dead_cnt = DEAD-1, go to IDLE.
- Round-robin pointer: only updated on a grant, so the zone just served has the lowest priority next.
- Counters are 8 bits. Comparisons are unsigned. Parameters outside their ranges are illegal.

## Timing

- Grant latency: req seen in IDLE at edge t → heater_on/cooler_on/valve high after edge t+1.
- A grant lasts at least MIN_ON cycles, unless the zone is disabled.
- A grant lasts exactly MIN_ON cycles if the request has already dropped.
- With other zones waiting, a grant lasts at most MAX_ON cycles.
- Release sequence: last RUN cycle → DEAD cycles of all-off → one IDLE cycle → next grant.
  - Minimum gap between grants is therefore DEAD+1 cycles with outputs off.
- Heater and cooler are never high in the same cycle. Consecutive grants of opposite mode are always separated by ≥ DEAD+1 off cycles.
- Request changes during DEAD or RUN (except the exit conditions) have no effect until IDLE.
- Reset mid-operation: rst_n low forces all outputs to 0 immediately, without waiting for a clock. The first grant after release occurs no earlier than the second rising edge after rst_n rises.

## Test plan

- Reset: rst_n = 0 mid-RUN with heater_on = 1 → heater_on, valve, busy go to 0 within the same cycle; ptr = 0 after release.
- Single request, defaults:
  - heat_req = 0100 at cycle 0, dropped at cycle 5 → valve = 0100, heater_on = 1 for cycles 1–16, off cycles 17–20 (busy = 1), IDLE at 21.
- Round-robin: all four zones cool_req held high →
  - grants go 0, 1, 2, 3, 0; each lasts 64 cycles;
  - 5 off cycles between grants;
  - cooler_on never overlaps a DEAD cycle.
- Preemption:
  - zone 1 heat held high, zone 3 cool raised at RUN cycle 10 → zone 1 released after RUN cycle 64;
  - zone 3 cooler_on starts 5 cycles later; heater_on and cooler_on never both 1.
- Disable: zone 0 granted; zone_en[0] drops at RUN cycle 3 → DEAD entered the next cycle; MIN_ON is not enforced.
- Conflict and frozen mode:
  - zone 2 heat and cool both high → heat granted;
  - heat dropped at cycle 20 with cool still high → released, then zone 2 re-granted as cool after DEAD+1 cycles.
